instr_fetch_unit: RTL

//  Instruction fetch and PC sequencer for the single-issue MIPS32 core. Produces
//  the instruction word and 6-bit opcode consumed by the control decoder. Consumes
//  the decoder's branch/jump flags plus the ALU zero flag to form the next PC.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_fetch_unit_next_pc_calc.sv | 31 +++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 opcode values, fetch FSM state type and fetch defaults.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } fetch_state_e;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: jump > beq-taken > bne-taken > sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] instr_i,
    input  logic        beq_i,
    input  logic        bne_i,
    input  logic        jump_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc4_o
);

    logic [31:0] br_target;

    // Jump is tested first so that undriven branch flags during a jump never reach the PC.
    always_comb begin
        pc4_o     = pc_i + 32'd4;
        br_target = pc4_o + branch_offset(instr_i[15:0]);
        next_pc_o = pc4_o;
        if (jump_i) begin
            next_pc_o = {pc4_o[31:28], instr_i, 2'b00};
        end else if (beq_i && zero_i) begin
            next_pc_o = br_target;
        end else if (bne_i && !zero_i) begin
            next_pc_o = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and PC sequencer: fetch one word, hold it until retired.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic        o_instr_valid,
    output logic [31:0] o_pc_plus4,
    input  logic        i_retire,
    input  logic        i_branch_beq,
    input  logic        i_branch_bne,
    input  logic        i_jump,
    input  logic        i_alu_zero
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         valid_q, valid_d;
    logic [31:0]  next_pc;
    logic [31:0]  pc4;

    next_pc_calc u_next_pc (
        .pc_i      (pc_q),
        .instr_i   (instr_q[25:0]),
        .beq_i     (i_branch_beq),
        .bne_i     (i_branch_bne),
        .jump_i    (i_jump),
        .zero_i    (i_alu_zero),
        .next_pc_o (next_pc),
        .pc4_o     (pc4)
    );

    // Fetch/issue sequencing: ack only matters in S_FETCH, retire only in S_ISSUE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        case (state_q)
            S_FETCH: begin
                if (i_imem_ack) begin
                    instr_d    = i_imem_data;
                    pc_plus4_d = pc4;
                    valid_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_retire) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_plus4_q <= RESET_PC + 32'd4;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // Request is masked by reset so an in-flight fetch is cancelled in the reset cycle.
    assign o_imem_req    = (state_q == S_FETCH) && !i_rst;
    assign o_imem_addr   = pc_q;
    assign o_instr       = instr_q;
    assign o_opcode      = instr_q[31:26];
    assign o_instr_valid = valid_q;
    assign o_pc_plus4    = pc_plus4_q;

endmodule
